clk_div_prog: RTL and testbench
===============================

// Module: clk_div_prog
// PURPOSE
//  Runtime-programmable integer clock divider/enable generator; successor to the fixed /2 divider in the fan controller.
//  Generates clk_out at f(clk_in)/N for any N in 1..2^DIV_W-1 with near-50% duty, plus a 1-cycle tick strobe per period.
//  N is reloadable on the fly. The new value takes effect only at a period boundary, so no runt pulses occur.
//  Feeds PWM/timing logic that needs a selectable time base from the system clock.
// PARAMETERS
//  DIV_W      16  width of divisor, counter and div_val/div_active
//  DIV_RESET  2   divisor after reset; must be 1..2^DIV_W-1 (2 = legacy /2 behaviour)
// PORTS
//  clk_in      in   1      system clock; all logic on its rising edge
//  rst_n       in   1      synchronous reset, active-low
//  en          in   1      count enable; 0 freezes the divider
//  restart     in   1      1-cycle strobe; forces a new period to start on this edge
//  div_load    in   1      1-cycle strobe; captures div_val as the pending divisor
//  div_val     in   DIV_W  requested divisor N; 0 is illegal
//  clk_out     out  1      divided clock, registered
//  tick        out  1      1-cycle pulse at the start of each period, registered
//  div_active  out  DIV_W  divisor currently in use
//  div_pending out  1      a valid load is waiting for the next boundary
//  div_err     out  1      1-cycle pulse: div_load was asserted with div_val==0
// BEHAVIOUR
//  Reset (rst_n=0 at an edge):
//   - cnt=DIV_RESET-1, div_active=DIV_RESET
//   - clk_out=0, tick=0, div_pending=0, div_err=0
//   - pending register cleared
//  Priority is rst_n > restart > en.
//  Period:
//   - cnt runs 0..N-1; H=ceil(N/2)=(N+1)>>1, computed DIV_W+1 bits wide so the max N does not overflow
//   - wrap edge: an enabled edge with cnt==div_active-1
//  Each enabled edge (en=1):
//   - cnt_nx = wrap ? 0 : cnt+1
//   - clk_out <= (cnt_nx < H)
//   - tick <= wrap
//  Result: clk_out is high for H cycles and low for N-H cycles; tick coincides with the rising edge of clk_out.
//  Latency: the first enabled edge after reset wraps, so clk_out=1 and tick=1 one cycle after reset release.
//  N=1: every enabled edge wraps; clk_out stays 1 and tick=1 every cycle.
//  Load:
//   - div_load with div_val!=0 writes the pending register and sets div_pending on the next edge
//   - a later load before the boundary overwrites the pending value (last write wins)
//  Apply:
//   - at a wrap edge or restart edge, if div_pending=1 or a valid div_load occurs on that same edge, div_active takes the new value (a same-edge div_load wins)
//   - div_pending clears on that edge
//   - the new period's H and wrap compare use the new N
//  div_val==0 with div_load: div_err=1 for one cycle; div_active and pending state are unchanged.
//  en=0:
//   - cnt, clk_out and div_active hold; tick=0
//   - loads are still captured as pending; no apply happens while disabled
//  restart=1 (ignores en):
//   - cnt <= 0, clk_out <= 1, tick <= 1
//   - applies any pending or same-edge valid load
//  Reset mid-period: behaves as reset; the pending load is lost.
// TESTING
//  1 Reset release, en=1 held, defaults -> clk_out=1,0,1,0,...; tick=1 on each high cycle; div_active=2.
//  2 N=2 running; div_load with div_val=5 mid-period -> div_pending=1 until the next wrap; then clk_out high 3 cycles, low 2; tick every 5 cycles.
//  3 Load div_val=1 -> after the boundary, clk_out held 1 and tick=1 every cycle; then load 3 -> high 2 cycles, low 1.
//  4 div_load with div_val=0 -> div_err one-cycle pulse; div_active and div_pending unchanged; waveform undisturbed.
//  5 en=0 for 7 cycles mid-period with a load of 4 during the gap -> outputs frozen, tick=0, div_pending=1; on en=1 the old period completes, then N=4 applies.
//  6 DIV_W=4, N=15; restart pulsed at cnt=9 -> next cycle clk_out=1 and tick=1; then 8 cycles high, 7 low; no overflow in H.

Source files
------------

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider: clk_out = clk_in/N with a tick strobe at each period start.
// Divisor reloads are held pending and applied only at a period boundary (wrap or restart).
module clk_div_prog #(
  parameter int DIV_W     = 16,
  parameter int DIV_RESET = 2
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             restart,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_val,
  output logic             clk_out,
  output logic             tick,
  output logic [DIV_W-1:0] div_active,
  output logic             div_pending,
  output logic             div_err
);

  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DIV_RESET);
  localparam logic [DIV_W-1:0] RST_CNT = DIV_W'(DIV_RESET - 1);

  // High-phase length ceil(N/2), one bit wider so N = 2^DIV_W-1 cannot overflow.
  function automatic logic [DIV_W:0] half_up(input logic [DIV_W-1:0] n);
    logic [DIV_W:0] s;
    s = {1'b0, n} + {{DIV_W{1'b0}}, 1'b1};
    return s >> 1;
  endfunction

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pend_val_q, pend_val_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;

  logic             load_ok;
  logic [DIV_W-1:0] last_cnt;
  logic             wrap;
  logic             apply;
  logic [DIV_W-1:0] cnt_nx;
  logic [DIV_W:0]   half;

  always_comb begin
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    clk_d      = clk_q;
    tick_d     = 1'b0;
    err_d      = div_load && (div_val == '0);

    load_ok  = div_load && (div_val != '0);
    last_cnt = div_q - 1'b1;
    wrap     = en && (cnt_q == last_cnt);
    apply    = (restart || wrap) && (pend_q || load_ok);

    // A same-edge load beats an older pending value.
    if (apply) begin
      div_d  = load_ok ? div_val : pend_val_q;
      pend_d = 1'b0;
    end else if (load_ok) begin
      pend_val_d = div_val;
      pend_d     = 1'b1;
    end

    half   = half_up(div_d);
    cnt_nx = wrap ? '0 : cnt_q + 1'b1;

    if (restart) begin
      cnt_d  = '0;
      clk_d  = 1'b1;
      tick_d = 1'b1;
    end else if (en) begin
      cnt_d  = cnt_nx;
      clk_d  = ({1'b0, cnt_nx} < half);
      tick_d = wrap;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      cnt_q      <= RST_CNT;
      div_q      <= RST_DIV;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      clk_q      <= 1'b0;
      tick_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      clk_q      <= clk_d;
      tick_q     <= tick_d;
      err_q      <= err_d;
    end
  end

  assign clk_out     = clk_q;
  assign tick        = tick_q;
  assign div_active  = div_q;
  assign div_pending = pend_q;
  assign div_err     = err_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: a 16-bit instance for the main scenarios and a
// 4-bit instance for the maximum-divisor / restart case.
module tb_clk_div_prog;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;

  // 16-bit instance, default divisor 2
  logic        rst_n, en, restart, div_load;
  logic [15:0] div_val;
  logic        clk_out, tick, div_pending, div_err;
  logic [15:0] div_active;

  clk_div_prog #(.DIV_W(16), .DIV_RESET(2)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .en(en), .restart(restart),
    .div_load(div_load), .div_val(div_val), .clk_out(clk_out), .tick(tick),
    .div_active(div_active), .div_pending(div_pending), .div_err(div_err)
  );

  // 4-bit instance for N = 15
  logic       rst_n_b, en_b, restart_b, div_load_b;
  logic [3:0] div_val_b;
  logic       clk_out_b, tick_b, div_pending_b, div_err_b;
  logic [3:0] div_active_b;

  clk_div_prog #(.DIV_W(4), .DIV_RESET(2)) dut_b (
    .clk_in(clk_in), .rst_n(rst_n_b), .en(en_b), .restart(restart_b),
    .div_load(div_load_b), .div_val(div_val_b), .clk_out(clk_out_b), .tick(tick_b),
    .div_active(div_active_b), .div_pending(div_pending_b), .div_err(div_err_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance one edge on the 16-bit instance and check clk_out/tick.
  task automatic cyc(input string tag, input logic c, input logic t);
    @(posedge clk_in); #1;
    check({tag, ".clk"}, 32'(clk_out), 32'(c));
    check({tag, ".tick"}, 32'(tick), 32'(t));
  endtask

  task automatic cyc_b(input string tag, input logic c, input logic t);
    @(posedge clk_in); #1;
    check({tag, ".clk"}, 32'(clk_out_b), 32'(c));
    check({tag, ".tick"}, 32'(tick_b), 32'(t));
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; restart = 1'b0; div_load = 1'b0; div_val = '0;
    rst_n_b = 1'b0; en_b = 1'b1; restart_b = 1'b0; div_load_b = 1'b0; div_val_b = '0;

    // 1: reset state, then legacy /2 waveform
    @(posedge clk_in); @(posedge clk_in); #1;
    check("rst.clk", 32'(clk_out), 0);
    check("rst.tick", 32'(tick), 0);
    check("rst.div_active", 32'(div_active), 2);
    check("rst.pending", 32'(div_pending), 0);
    check("rst.err", 32'(div_err), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc($sformatf("t1.hi%0d", i), 1'b1, 1'b1);
      cyc($sformatf("t1.lo%0d", i), 1'b0, 1'b0);
    end
    check("t1.div_active", 32'(div_active), 2);

    // 2: load 5 mid-period, pending until the next wrap
    cyc("t2.pre", 1'b1, 1'b1);
    div_load = 1'b1; div_val = 16'd5;
    cyc("t2.load", 1'b0, 1'b0);
    div_load = 1'b0; div_val = '0;
    check("t2.pending", 32'(div_pending), 1);
    check("t2.active_old", 32'(div_active), 2);
    for (int p = 0; p < 2; p++) begin
      cyc($sformatf("t2.p%0d.c0", p), 1'b1, 1'b1);
      if (p == 0) begin
        check("t2.active_new", 32'(div_active), 5);
        check("t2.pending_clr", 32'(div_pending), 0);
      end
      cyc($sformatf("t2.p%0d.c1", p), 1'b1, 1'b0);
      cyc($sformatf("t2.p%0d.c2", p), 1'b1, 1'b0);
      cyc($sformatf("t2.p%0d.c3", p), 1'b0, 1'b0);
      cyc($sformatf("t2.p%0d.c4", p), 1'b0, 1'b0);
    end

    // 3: load 1 (pending), then a same-edge load of 3 at a wrap
    cyc("t3.pre", 1'b1, 1'b1);
    div_load = 1'b1; div_val = 16'd1;
    cyc("t3.load1", 1'b1, 1'b0);
    div_load = 1'b0; div_val = '0;
    check("t3.pending", 32'(div_pending), 1);
    cyc("t3.c2", 1'b1, 1'b0);
    cyc("t3.c3", 1'b0, 1'b0);
    cyc("t3.c4", 1'b0, 1'b0);
    cyc("t3.apply1", 1'b1, 1'b1);
    check("t3.active1", 32'(div_active), 1);
    for (int i = 0; i < 3; i++) cyc($sformatf("t3.n1_%0d", i), 1'b1, 1'b1);
    div_load = 1'b1; div_val = 16'd3;
    cyc("t3.apply3", 1'b1, 1'b1);
    div_load = 1'b0; div_val = '0;
    check("t3.active3", 32'(div_active), 3);
    check("t3.pending3", 32'(div_pending), 0);
    cyc("t3.n3_c1", 1'b1, 1'b0);
    cyc("t3.n3_c2", 1'b0, 1'b0);
    cyc("t3.n3_w", 1'b1, 1'b1);
    cyc("t3.n3_c1b", 1'b1, 1'b0);
    cyc("t3.n3_c2b", 1'b0, 1'b0);

    // 4: illegal zero load flags an error and changes nothing
    div_load = 1'b1; div_val = 16'd0;
    cyc("t4.w", 1'b1, 1'b1);
    div_load = 1'b0;
    check("t4.err", 32'(div_err), 1);
    check("t4.active", 32'(div_active), 3);
    check("t4.pending", 32'(div_pending), 0);
    cyc("t4.c1", 1'b1, 1'b0);
    check("t4.err_clr", 32'(div_err), 0);
    cyc("t4.c2", 1'b0, 1'b0);

    // 5: freeze for 7 cycles with a load of 4 in the gap
    cyc("t5.w", 1'b1, 1'b1);
    cyc("t5.c1", 1'b1, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) begin div_load = 1'b1; div_val = 16'd4; end
      else begin div_load = 1'b0; div_val = '0; end
      cyc($sformatf("t5.hold%0d", i), 1'b1, 1'b0);
    end
    check("t5.pending", 32'(div_pending), 1);
    check("t5.active_old", 32'(div_active), 3);
    en = 1'b1;
    cyc("t5.c2", 1'b0, 1'b0);
    cyc("t5.apply", 1'b1, 1'b1);
    check("t5.active_new", 32'(div_active), 4);
    cyc("t5.n4_c1", 1'b1, 1'b0);
    cyc("t5.n4_c2", 1'b0, 1'b0);
    cyc("t5.n4_c3", 1'b0, 1'b0);
    cyc("t5.n4_w", 1'b1, 1'b1);

    // 6: DIV_W=4, N=15, restart at cnt=9 (with en low to show it is ignored)
    rst_n_b = 1'b1;
    cyc_b("t6.first", 1'b1, 1'b1);
    div_load_b = 1'b1; div_val_b = 4'd15;
    cyc_b("t6.load", 1'b0, 1'b0);
    div_load_b = 1'b0; div_val_b = '0;
    cyc_b("t6.apply", 1'b1, 1'b1);
    check("t6.active", 32'(div_active_b), 15);
    for (int k = 1; k <= 9; k++) cyc_b($sformatf("t6.pre%0d", k), (k < 8), 1'b0);
    restart_b = 1'b1; en_b = 1'b0;
    cyc_b("t6.restart", 1'b1, 1'b1);
    restart_b = 1'b0; en_b = 1'b1;
    for (int k = 1; k <= 14; k++) cyc_b($sformatf("t6.cnt%0d", k), (k < 8), 1'b0);
    cyc_b("t6.wrap", 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
